// File: rtl/sram_arbiter.sv
// SRAM arbiter: SPI toggle-handshake and CPU level requests share one async 16-bit SRAM.
// Define SRAM_ARB_ROUND_ROBIN_EN for alternating grants; otherwise SPI has fixed priority.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 3,
  parameter int ADDR_W        = 19
) (
  input  logic              clk200,
  input  logic              rst_n,
  input  logic              spi_req,
  output logic              spi_ack,
  input  logic              spi_read_sram,
  input  logic [ADDR_W-1:0] spi_address_sram,
  input  logic              spi_ub,
  input  logic [7:0]        spi_out_sram_in,
  output logic [15:0]       spi_in_sram_out,
  input  logic              cpu_req,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_ub_n,
  input  logic              cpu_lb_n,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] sram_address,
  output logic [15:0]       sram_data_out,
  output logic              sram_data_oe,
  input  logic [15:0]       sram_data_in,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam int              CNT_W    = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_grant_cpu;
  logic              r_is_read;
  logic              r_spi_ack;
  logic              r_cpu_ack;
  logic [15:0]       r_spi_rdata;
  logic [15:0]       r_cpu_rdata;
  logic [ADDR_W-1:0] r_sram_address;
  logic [15:0]       r_sram_data_out;
  logic              r_sram_data_oe;
  logic              r_sram_we_n;
  logic              r_sram_oe_n;
  logic              r_sram_ub_n;
  logic              r_sram_lb_n;

  logic              w_spi_pend;
  logic              w_cpu_pend;
  logic              w_pick_cpu;
  logic              w_sel_read;
  logic              w_sel_ub_n;
  logic              w_sel_lb_n;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [15:0]       w_sel_wdata;

  // The ack cycle itself must not look like a fresh CPU request.
  assign w_spi_pend = spi_req ^ r_spi_ack;
  assign w_cpu_pend = cpu_req & ~r_cpu_ack;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic r_last_cpu;

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      r_last_cpu <= 1'b1;
    end else if (r_state == ST_RECOVER) begin
      r_last_cpu <= r_grant_cpu;
    end
  end

  assign w_pick_cpu = w_cpu_pend & (~w_spi_pend | ~r_last_cpu);
`else
  assign w_pick_cpu = w_cpu_pend & ~w_spi_pend;
`endif

  // Reads always open both lanes; SPI byte writes replicate the byte onto both halves.
  always_comb begin
    w_sel_read  = spi_read_sram;
    w_sel_addr  = spi_address_sram;
    w_sel_wdata = {spi_out_sram_in, spi_out_sram_in};
    w_sel_ub_n  = spi_read_sram ? 1'b0 : ~spi_ub;
    w_sel_lb_n  = spi_read_sram ? 1'b0 : spi_ub;
    if (w_pick_cpu) begin
      w_sel_read  = cpu_read;
      w_sel_addr  = cpu_address;
      w_sel_wdata = cpu_wdata;
      w_sel_ub_n  = cpu_read ? 1'b0 : cpu_ub_n;
      w_sel_lb_n  = cpu_read ? 1'b0 : cpu_lb_n;
    end
  end

  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_grant_cpu     <= 1'b0;
      r_is_read       <= 1'b0;
      r_spi_ack       <= 1'b0;
      r_cpu_ack       <= 1'b0;
      r_spi_rdata     <= '0;
      r_cpu_rdata     <= '0;
      r_sram_address  <= '0;
      r_sram_data_out <= '0;
      r_sram_data_oe  <= 1'b0;
      r_sram_we_n     <= 1'b1;
      r_sram_oe_n     <= 1'b1;
      r_sram_ub_n     <= 1'b1;
      r_sram_lb_n     <= 1'b1;
    end else begin
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_spi_pend || w_cpu_pend) begin
            r_grant_cpu     <= w_pick_cpu;
            r_is_read       <= w_sel_read;
            r_sram_address  <= w_sel_addr;
            r_sram_data_out <= w_sel_wdata;
            r_sram_oe_n     <= ~w_sel_read;
            r_sram_we_n     <= w_sel_read;
            r_sram_data_oe  <= ~w_sel_read;
            r_sram_ub_n     <= w_sel_ub_n;
            r_sram_lb_n     <= w_sel_lb_n;
            r_cnt           <= '0;
            r_state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            if (r_is_read) begin
              if (r_grant_cpu) begin
                r_cpu_rdata <= sram_data_in;
              end else begin
                r_spi_rdata <= sram_data_in;
              end
            end
            r_sram_oe_n    <= 1'b1;
            r_sram_we_n    <= 1'b1;
            r_sram_ub_n    <= 1'b1;
            r_sram_lb_n    <= 1'b1;
            r_sram_data_oe <= 1'b0;
            r_state        <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          if (r_grant_cpu) begin
            r_cpu_ack <= 1'b1;
          end else begin
            r_spi_ack <= ~r_spi_ack;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi_ack         = r_spi_ack;
  assign spi_in_sram_out = r_spi_rdata;
  assign cpu_ack         = r_cpu_ack;
  assign cpu_rdata       = r_cpu_rdata;
  assign sram_address    = r_sram_address;
  assign sram_data_out   = r_sram_data_out;
  assign sram_data_oe    = r_sram_data_oe;
  assign sram_we_n       = r_sram_we_n;
  assign sram_oe_n       = r_sram_oe_n;
  assign sram_ub_n       = r_sram_ub_n;
  assign sram_lb_n       = r_sram_lb_n;

endmodule
